// File: rtl/pal_csync_gen_if.sv
// Signal bundle between the PAL timing generator and its consumer.
// The generator takes the pixel advance enable and drives the timing outputs.
interface pal_csync_gen_if;
  logic       pixel_ce;
  logic       csync;
  logic       hsync;
  logic       vsync;
  logic       odd_field;
  logic [9:0] line;
  logic [9:0] hcount;
  logic       display_en;
  logic       frame_start;

  modport master (
    input  pixel_ce,
    output csync, hsync, vsync, odd_field, line, hcount, display_en, frame_start
  );

  modport slave (
    output pixel_ce,
    input  csync, hsync, vsync, odd_field, line, hcount, display_en, frame_start
  );
endinterface

// File: rtl/pal_csync_gen.sv
// PAL 625-line interlaced timing generator: composite sync with equalising and
// broad pulses, separated syncs, field flag, position and display enable.
module pal_csync_gen #(
  parameter int LINE_CLKS      = 864,
  parameter int HSYNC_CLKS     = 64,
  parameter int EQ_CLKS        = 32,
  parameter int BROAD_CLKS     = 368,
  parameter int H_ACTIVE_START = 132,
  parameter int H_ACTIVE_CLKS  = 720
) (
  input  logic             clk,
  input  logic             reset,
  pal_csync_gen_if.master  bus
);

  localparam logic [9:0]  LAST_H   = 10'(LINE_CLKS - 1);
  localparam logic [9:0]  HALF_H   = 10'(LINE_CLKS / 2);
  localparam logic [9:0]  HSYNC_W  = 10'(HSYNC_CLKS);
  localparam logic [9:0]  EQ_W     = 10'(EQ_CLKS);
  localparam logic [9:0]  BROAD_W  = 10'(BROAD_CLKS);
  localparam logic [10:0] ACT_FROM = 11'(H_ACTIVE_START);
  localparam logic [10:0] ACT_TO   = 11'(H_ACTIVE_START + H_ACTIVE_CLKS);

  localparam logic [1:0] SEG_NORMAL = 2'd0;
  localparam logic [1:0] SEG_EQ     = 2'd1;
  localparam logic [1:0] SEG_BROAD  = 2'd2;
  localparam logic [1:0] SEG_NONE   = 2'd3;

  logic [9:0] pos_line_q, pos_line_d;
  logic [9:0] pos_h_q, pos_h_d;

  logic       csync_q, csync_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       odd_q, odd_d;
  logic [9:0] line_q;
  logic [9:0] hcount_q;
  logic       de_q, de_d;
  logic       fs_q, fs_d;

  logic       half_d;
  logic [9:0] off_d;
  logic [1:0] seg_d;
  logic [9:0] width_d;
  logic       in_broad_d, in_eq_d, in_rows_d;

  // Next position; the output registers always describe this position.
  always_comb begin
    pos_h_d    = pos_h_q + 10'd1;
    pos_line_d = pos_line_q;
    if (pos_h_q == LAST_H) begin
      pos_h_d    = 10'd0;
      pos_line_d = (pos_line_q == 10'd625) ? 10'd1 : pos_line_q + 10'd1;
    end
  end

  always_comb begin
    half_d = (pos_h_d >= HALF_H);
    off_d  = half_d ? (pos_h_d - HALF_H) : pos_h_d;

    in_broad_d = (pos_line_d inside {10'd1, 10'd2, 10'd314, 10'd315})
               || (pos_line_d == 10'd3   && !half_d)
               || (pos_line_d == 10'd313 &&  half_d);
    in_eq_d    = (pos_line_d inside {10'd4, 10'd5, 10'd311, 10'd312,
                                     10'd316, 10'd317, 10'd624, 10'd625})
               || (pos_line_d == 10'd3   &&  half_d)
               || (pos_line_d == 10'd313 && !half_d)
               || (pos_line_d == 10'd318 && !half_d)
               || (pos_line_d == 10'd623 &&  half_d);

    seg_d = half_d ? SEG_NONE : SEG_NORMAL;
    if (in_broad_d) begin
      seg_d = SEG_BROAD;
    end else if (in_eq_d) begin
      seg_d = SEG_EQ;
    end

    case (seg_d)
      SEG_NORMAL: width_d = HSYNC_W;
      SEG_EQ:     width_d = EQ_W;
      SEG_BROAD:  width_d = BROAD_W;
      default:    width_d = 10'd0;
    endcase

    in_rows_d = (pos_line_d >= 10'd23  && pos_line_d <= 10'd310)
             || (pos_line_d >= 10'd336 && pos_line_d <= 10'd623);

    csync_d = !(off_d < width_d);
    hsync_d = (pos_h_d < HSYNC_W);
    vsync_d = (seg_d == SEG_BROAD);
    odd_d   = (pos_line_d <= 10'd312);
    de_d    = in_rows_d && ({1'b0, pos_h_d} >= ACT_FROM) && ({1'b0, pos_h_d} < ACT_TO);
    fs_d    = (pos_line_d == 10'd1) && (pos_h_d == 10'd0);
  end

  // Position is preset to the last count of the frame so the first ce shows line 1, hcount 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_line_q <= 10'd625;
      pos_h_q    <= LAST_H;
      csync_q    <= 1'b1;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      odd_q      <= 1'b1;
      line_q     <= 10'd1;
      hcount_q   <= 10'd0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else if (bus.pixel_ce) begin
      pos_line_q <= pos_line_d;
      pos_h_q    <= pos_h_d;
      csync_q    <= csync_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      odd_q      <= odd_d;
      line_q     <= pos_line_d;
      hcount_q   <= pos_h_d;
      de_q       <= de_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.csync       = csync_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.odd_field   = odd_q;
  assign bus.line        = line_q;
  assign bus.hcount      = hcount_q;
  assign bus.display_en  = de_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_pal_csync_gen.sv
// Bench for pal_csync_gen: a default-rate instance and a scaled instance (64-clk
// lines) share reset and pixel_ce and are compared against a half-line model.
module tb_pal_csync_gen;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  always #5 clk = ~clk;

  pal_csync_gen_if bi ();
  pal_csync_gen_if si ();
  assign bi.pixel_ce = ce;
  assign si.pixel_ce = ce;

  pal_csync_gen u_big (.clk(clk), .reset(reset), .bus(bi.master));

  pal_csync_gen #(
    .LINE_CLKS(64), .HSYNC_CLKS(5), .EQ_CLKS(2), .BROAD_CLKS(27),
    .H_ACTIVE_START(10), .H_ACTIVE_CLKS(50)
  ) u_small (.clk(clk), .reset(reset), .bus(si.master));

  localparam int BIG_FRAME   = 540000;
  localparam int SMALL_FRAME = 40000;
  localparam logic [25:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 10'd0, 1'b0, 1'b0};

  wire [25:0] big_vec   = {bi.csync, bi.hsync, bi.vsync, bi.odd_field, bi.line, bi.hcount,
                           bi.display_en, bi.frame_start};
  wire [25:0] small_vec = {si.csync, si.hsync, si.vsync, si.odd_field, si.line, si.hcount,
                           si.display_en, si.frame_start};

  int errors = 0;
  int checks = 0;
  bit rs;
  int tb_t, ts_t;

  typedef struct {
    bit         sel;   // 0 = default instance, 1 = scaled instance
    int         t;     // ce index after reset
    logic [4:0] exp;   // {csync, hsync, vsync, odd_field, display_en}
  } vec_t;
  vec_t tbl[48];
  int   ntbl = 0;

  task automatic add(input bit sel, input int ln, input int h, input int lc, input logic [4:0] e);
    tbl[ntbl] = '{sel: sel, t: (ln - 1) * lc + h, exp: e};
    ntbl++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: frame seen as 1250 half-lines, each with one sync pulse width.
  function automatic logic [25:0] model(input int lc, input int hs, input int eqw, input int brw,
                                        input int has, input int hac, input int t, input bit r);
    int ln, h, hh, hl, off, w;
    bit is_broad, is_eq, cs, de;
    if (r) return RESET_VEC;
    ln = t / lc + 1;
    h  = t % lc;
    hh = lc / 2;
    hl = t / hh;
    off = t % hh;
    is_broad = (hl <= 4) || (hl >= 625 && hl <= 629);
    is_eq    = (hl >= 5 && hl <= 9) || (hl >= 620 && hl <= 624) ||
               (hl >= 630 && hl <= 634) || (hl >= 1245);
    if (is_broad)        w = brw;
    else if (is_eq)      w = eqw;
    else if (hl % 2 == 0) w = hs;
    else                 w = 0;
    cs = !(off < w);
    de = ((ln >= 23 && ln <= 310) || (ln >= 336 && ln <= 623)) && h >= has && h < has + hac;
    return {cs, (h < hs), is_broad, (ln <= 312), 10'(ln), 10'(h), de, (t == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) rs = 1'b1;
    else if (ce) begin
      if (rs) begin
        rs = 1'b0; tb_t = 0; ts_t = 0;
      end else begin
        tb_t = (tb_t + 1) % BIG_FRAME;
        ts_t = (ts_t + 1) % SMALL_FRAME;
      end
    end
    chk($sformatf("big_model t=%0d rs=%0d", tb_t, rs), 32'(big_vec),
        32'(model(864, 64, 32, 368, 132, 720, tb_t, rs)));
    chk($sformatf("small_model t=%0d rs=%0d", ts_t, rs), 32'(small_vec),
        32'(model(64, 5, 2, 27, 10, 50, ts_t, rs)));
  endtask

  initial begin
    int fe, fsc, dec, lchg, seq_bad, cl_s, cl_b;
    logic prev_cs;
    logic [9:0] prev_line;
    logic [4:0] got5;

    // Default instance: line 1 broad pulses, line 3 eq, line 6 normal, line 23 active edges.
    add(0, 1, 0, 864, 5'b01110);   add(0, 1, 367, 864, 5'b00110);
    add(0, 1, 368, 864, 5'b10110); add(0, 1, 431, 864, 5'b10110);
    add(0, 1, 432, 864, 5'b00110); add(0, 1, 799, 864, 5'b00110);
    add(0, 1, 800, 864, 5'b10110); add(0, 1, 863, 864, 5'b10110);
    add(0, 3, 432, 864, 5'b00010); add(0, 3, 464, 864, 5'b10010);
    add(0, 6, 0, 864, 5'b01010);   add(0, 6, 63, 864, 5'b01010);
    add(0, 6, 64, 864, 5'b10010);  add(0, 6, 432, 864, 5'b10010);
    add(0, 6, 500, 864, 5'b10010);
    add(0, 23, 0, 864, 5'b01010);  add(0, 23, 131, 864, 5'b10010);
    add(0, 23, 132, 864, 5'b10011); add(0, 23, 851, 864, 5'b10011);
    add(0, 23, 852, 864, 5'b10010);
    // Scaled instance: field boundary lines 310-318, 336 and 623.
    add(1, 310, 10, 64, 5'b10011); add(1, 311, 10, 64, 5'b10010);
    add(1, 312, 63, 64, 5'b10010);
    add(1, 313, 0, 64, 5'b01000);  add(1, 313, 1, 64, 5'b01000);
    add(1, 313, 2, 64, 5'b11000);  add(1, 313, 5, 64, 5'b10000);
    add(1, 313, 31, 64, 5'b10000); add(1, 313, 32, 64, 5'b00100);
    add(1, 313, 58, 64, 5'b00100); add(1, 313, 59, 64, 5'b10100);
    add(1, 318, 0, 64, 5'b01000);  add(1, 318, 2, 64, 5'b11000);
    add(1, 318, 32, 64, 5'b10000); add(1, 318, 40, 64, 5'b10000);
    add(1, 336, 10, 64, 5'b10001);
    add(1, 623, 59, 64, 5'b10001); add(1, 623, 60, 64, 5'b10000);

    rs = 1'b1; tb_t = 0; ts_t = 0;
    ce = 1'b0; reset = 1'b1;
    repeat (3) tick();
    chk("reset_state_big", 32'(big_vec), 32'(RESET_VEC));
    chk("reset_state_small", 32'(small_vec), 32'(RESET_VEC));

    // Full frame of the scaled instance with continuous ce.
    reset = 1'b0; ce = 1'b1;
    fe = 0; fsc = 0; dec = 0; lchg = 0; seq_bad = 0;
    prev_cs = si.csync; prev_line = si.line;
    for (int n = 0; n < SMALL_FRAME; n++) begin
      tick();
      for (int k = 0; k < ntbl; k++) begin
        if (tbl[k].t == n) begin
          got5 = tbl[k].sel ? {si.csync, si.hsync, si.vsync, si.odd_field, si.display_en}
                            : {bi.csync, bi.hsync, bi.vsync, bi.odd_field, bi.display_en};
          chk($sformatf("table%0d sel=%0d t=%0d", k, tbl[k].sel, n), 32'(got5), 32'(tbl[k].exp));
        end
      end
      if (prev_cs && !si.csync) fe++;
      if (si.frame_start) fsc++;
      if (si.display_en) dec++;
      if (si.line != prev_line) begin
        lchg++;
        if (!(si.line == prev_line + 10'd1 || (prev_line == 10'd625 && si.line == 10'd1))) seq_bad++;
      end
      prev_cs = si.csync; prev_line = si.line;
    end
    chk("frame_csync_falls", 32'(fe), 32'd640);
    chk("frame_start_count", 32'(fsc), 32'd1);
    chk("display_en_count", 32'(dec), 32'(576 * 50));
    chk("line_changes", 32'(lchg), 32'd624);
    chk("line_sequence", 32'(seq_bad), 32'd0);
    tick();
    chk("frame_wrap", 32'({si.line, si.hcount, si.frame_start}), 32'({10'd1, 10'd0, 1'b1}));

    // Reset for one clk at line 200, hcount 50 of the scaled instance.
    for (int n = 0; n < 12786; n++) tick();
    chk("pre_reset_pos", 32'({si.line, si.hcount}), 32'({10'd200, 10'd50}));
    reset = 1'b1; ce = 1'b1;
    tick();
    chk("mid_reset_state", 32'(small_vec), 32'(RESET_VEC));
    reset = 1'b0; ce = 1'b0;
    tick(); tick();
    ce = 1'b1;
    tick();
    chk("post_reset_small", 32'({si.csync, si.line, si.hcount, si.frame_start}),
        32'({1'b0, 10'd1, 10'd0, 1'b1}));
    chk("post_reset_big", 32'({bi.csync, bi.line, bi.hcount, bi.frame_start}),
        32'({1'b0, 10'd1, 10'd0, 1'b1}));

    // pixel_ce every other clk: pulse widths double in clk terms.
    reset = 1'b1; ce = 1'b0;
    tick();
    reset = 1'b0;
    cl_s = 0; cl_b = 0;
    for (int c = 1; c <= 800; c++) begin
      ce = (c % 2 == 1);
      tick();
      if (c <= 60 && !si.csync) cl_s++;
      if (!bi.csync) cl_b++;
    end
    chk("half_rate_broad_small", 32'(cl_s), 32'd54);
    chk("half_rate_broad_big", 32'(cl_b), 32'd736);

    // Random ce with occasional reset.
    for (int n = 0; n < 15000; n++) begin
      ce    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 4999) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pal_csync_gen.md
# pal_csync_gen

- Generates a standard PAL 625-line interlaced timing stream (two fields per frame).
- Outputs:
  - active-low composite sync with equalising and broad pulses, in the same form as the AIV csync input;
  - separated hsync/vsync, odd_field, line/horizontal position, display enable and a frame-start strobe.
- Sits on the SCART output side as the transmit counterpart of the sync separator and pixel tracker.
- Lets the SCART csync be generated locally instead of derived from the Pi hsync/vsync, and provides timing for loopback testing of the AIV capture path.

## Interface

Parameters (all in pixel_ce counts; defaults for a 13.5 MHz pixel rate):
- LINE_CLKS, 864, full line period (64 µs); must be even and ≤ 1024.
- HSYNC_CLKS, 64, normal line sync low width (4.7 µs).
- EQ_CLKS, 32, equalising pulse low width (2.35 µs).
- BROAD_CLKS, 368, broad pulse low width (LINE_CLKS/2 − HSYNC_CLKS).
- H_ACTIVE_START, 132, first active hcount.
- H_ACTIVE_CLKS, 720, active width; H_ACTIVE_START + H_ACTIVE_CLKS ≤ LINE_CLKS.

Ports:
- clk, input, 1, system clock, the single clock.
- reset, input, 1, synchronous, active-high.
- pixel_ce, input, 1, advance enable; the position advances one count per clk with pixel_ce=1.
- csync, output, 1, composite sync, active low.
- hsync, output, 1, active high for the first HSYNC_CLKS of every line.
- vsync, output, 1, active high during the broad-pulse interval.
- odd_field, output, 1, 1 for lines 1–312, 0 for lines 313–625.
- line, output, 10, current line, 1–625.
- hcount, output, 10, position in line, 0 to LINE_CLKS−1.
- display_en, output, 1, active picture area.
- frame_start, output, 1, one-ce strobe at line 1, hcount 0.

## Operation

- **Position counter**
  - hcount counts 0 to LINE_CLKS−1 and wraps to 0.
  - On wrap, line increments; line 625 wraps to 1.
  - HALF = LINE_CLKS/2. Half 0 is hcount < HALF; half 1 is hcount ≥ HALF.
- **Segment type**, decoded from (line, half):
  - BROAD: lines 1–2 both halves; line 3 half 0; line 313 half 1; lines 314–315 both halves.
  - EQ: line 3 half 1; lines 4–5; lines 311–312; line 313 half 0; lines 316–317; line 318 half 0; line 623 half 1; lines 624–625.
  - NONE: line 318 half 1; half 1 of every remaining line.
  - NORMAL: half 0 of every remaining line.
- **csync**: low while the offset within the half (hcount or hcount−HALF) is below the segment's width:
  - NORMAL uses HSYNC_CLKS;
  - EQ uses EQ_CLKS;
  - BROAD uses BROAD_CLKS;
  - NONE keeps csync high.
- **vsync**: high from line 1 hcount 0 to line 3 hcount HALF−1, and from line 313 hcount HALF to line 315 hcount LINE_CLKS−1.
- **hsync**: high when hcount < HSYNC_CLKS, on all 625 lines, regardless of segment type.
- **display_en**: high when both hold:
  - line is in 23–310 or 336–623;
  - H_ACTIVE_START ≤ hcount < H_ACTIVE_START + H_ACTIVE_CLKS.
- **frame_start**: high for exactly one pixel_ce period, while the position is line 1, hcount 0.
- **Alignment**: all outputs are registered and mutually aligned; line and hcount are the position the other outputs describe.

## Timing

- **Reset values**: csync=1, hsync=0, vsync=0, odd_field=1, line=1, hcount=0, display_en=0, frame_start=0. The internal position is preset so the next ce emits line 1, hcount 0.
- **First ce after reset release**:
  - outputs show line 1, hcount 0;
  - csync=0, vsync=1, hsync=1, frame_start=1.
- **Latency**: each subsequent ce advances the outputs by one position.
- **pixel_ce=0**: all outputs hold, including a frame_start that is high.
- **Reset mid-frame**: reset takes effect on the next clk edge, whatever the pixel_ce value, and re-runs the reset sequence above. No partial pulse is completed.
- **Simultaneous events**: reset takes priority over pixel_ce. At the hcount wrap, line and hcount update in the same ce; there is no intermediate state.

## Test plan

- **Reset, then continuous pixel_ce=1**, at line 1:
  - csync low for hcount 0–367, high 368–431, low 432–799, high 800–863;
  - vsync=1 and frame_start=1 for exactly one clk.
- **Line 6**: csync and hsync low/high for hcount 0–63 only, csync high otherwise; vsync=0, odd_field=1, display_en=0.
- **Lines 313 and 318**:
  - line 313: csync low for hcount 0–31 (EQ), low for 432–799 (BROAD); vsync rises at hcount 432; odd_field=0.
  - line 318: low for 0–31, then no pulse at 432.
- **Full frame (540000 ce)**:
  - exactly 640 csync falling edges;
  - one frame_start;
  - line sequence 1…625 then back to 1;
  - display_en high for 576×720 ce.
- **pixel_ce asserted every other clk**: all pulse widths double in clk terms; outputs are stable on clks with pixel_ce=0; the pattern is otherwise identical to the first scenario.
- **Reset for 1 clk at line 200, hcount 500**: the next ce gives line 1, hcount 0, csync=0, frame_start=1; no residual pulse from line 200.
